race_game_fsm: RTL and testbench
================================

# race_game_fsm

Game-control stage that consumes the per-pixel layer outputs (player car, moving traffic) and the pixel coordinates produced by the display pipeline. It detects player/traffic overlap, runs the IDLE/RUN/CRASH game state machine, keeps a per-frame score, and drives the 2-bit `level` that selects road and traffic speed. It sits beside the compositor on the VGA pixel clock. Its `start` input and its status outputs connect to the Wishbone register bank.

## Interface

**Parameters**

- `ACTIVE_ROWS`, default 480: first non-visible row. The frame-end tick is derived from it.
- `OVERLAP_MIN`, default 4: overlapping pixels in one frame that count as a crash. Legal range 1..65535.
- `LEVEL_FRAMES`, default 1800: RUN frames per level step.
- `CRASH_FRAMES`, default 120: frames spent in CRASH before returning to IDLE.

**Ports** (direction, width, meaning)

- `clk`, in, 1: VGA pixel clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pix_row`, in, 10: current pixel row.
- `pix_col`, in, 10: current pixel column.
- `video_on`, in, 1: visible-region qualifier.
- `player_car_in`, in, 12: player layer RGB. `12'h000` means transparent.
- `moving_cars_in`, in, 12: traffic layer RGB. `12'h000` means transparent.
- `start`, in, 1: level signal from the register bank; only its rising edge is used.
- `game_state`, out, 2: 0 = IDLE, 1 = RUN, 2 = CRASH.
- `crash`, out, 1: high while in CRASH.
- `score`, out, 16: RUN frames completed; saturates at 16'hFFFF.
- `level`, out, 2: 0..3, saturating.
- `frame_tick`, out, 1: one-cycle pulse at each frame end.

## Operation

- **Input stage:** all inputs are registered once. The `start` rising edge is detected on the registered copy.
- **Overlap test:** a pixel overlaps when all of these hold in the registered stage:
  - `video_on` is high;
  - `player_car_in` is not `12'h000`;
  - `moving_cars_in` is not `12'h000`.
- **Overlap counter:** 16 bits, saturating. It increments on every overlapping pixel and clears on the cycle after `frame_tick`.
- **Frame end:** `frame_tick` fires on the rising edge of (registered `pix_row` ≥ `ACTIVE_ROWS`). This gives exactly one tick per frame.

**State machine** (all decisions except the IDLE→RUN start edge are taken only on `frame_tick`)

- **IDLE → RUN:** on the `start` rising edge, in any cycle. On entry:
  - `score` ← 0;
  - `level` ← 0;
  - frame counters ← 0;
  - overlap counter ← 0.
- **RUN → CRASH:** at `frame_tick`, if the overlap count ≥ `OVERLAP_MIN`. `score` is not incremented for that frame.
- **RUN, no crash at `frame_tick`:**
  - `score` += 1, saturating;
  - the level frame counter += 1;
  - when the level frame counter reaches `LEVEL_FRAMES`, it wraps to 0 and `level` += 1, saturating at 3.
- **CRASH → IDLE:** after `CRASH_FRAMES` `frame_tick`s. The crash counter clears on entry to CRASH.
- **In CRASH and IDLE:** `score` and `level` hold so the last result stays readable.
- **`start` edge while in RUN or CRASH:** ignored. A `start` held high through CRASH→IDLE does not restart; a fresh rising edge is required.
- **Start edge and `frame_tick` in the same cycle while in IDLE:** the start wins. That tick is not scored, and the frame counts from the next tick.
- **Reset:** asynchronous at any point, including mid-frame or mid-CRASH. Reset values of every output and internal register:
  - `game_state` = IDLE;
  - `crash` = 0;
  - `score` = 0;
  - `level` = 0;
  - `frame_tick` = 0;
  - all counters = 0;
  - input registers = 0.

## Timing

- Pixel to overlap counter: 2 cycles (input register, then counter update).
- `frame_tick` asserts 2 cycles after the `pix_row` input first reaches `ACTIVE_ROWS`.
- `game_state`, `crash`, `score` and `level` update in the cycle after `frame_tick`.
- `start` edge to RUN: 2 cycles (input register, then state register).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- **`CRASH_IRQ_EN` defined:**
  - adds output `crash_irq` (1 bit) and input `irq_clr` (1 bit);
  - `crash_irq` sets on the RUN→CRASH transition and stays set until `irq_clr` is sampled high;
  - if set and clear occur in the same cycle, set wins;
  - `crash_irq` resets to 0.
- **`CRASH_IRQ_EN` undefined:** neither port exists. All other behaviour is identical.

## Test plan

1. **Reset:** assert `rst_n` = 0 mid-frame while in RUN with `score` = 5. Required: all outputs 0 and `game_state` = IDLE asynchronously; they stay there after release until a `start` edge.
2. **Clean run:** pulse `start`, then run 10 frames with disjoint car and traffic pixels. Required: `score` = 10, `level` = 0, `crash` = 0, and exactly 10 `frame_tick` pulses.
3. **Crash threshold:** with `OVERLAP_MIN` = 4:
   - 3 overlapping pixels in a frame → stays in RUN and `score` increments;
   - 4 overlapping pixels in the next frame → CRASH, `crash` = 1, `score` unchanged.
4. **Crash hold:** with `CRASH_FRAMES` = 3, after a crash:
   - IDLE is reached exactly at the 3rd `frame_tick`;
   - a `start` edge issued during CRASH is ignored;
   - a new `start` edge in IDLE clears `score` and enters RUN.
5. **Level saturation:** with `LEVEL_FRAMES` = 2, run 10 clean frames. Required: `level` steps 0→1→2→3 at frames 2, 4, 6 and stays at 3.
6. **IRQ (`CRASH_IRQ_EN`):** after a crash, `crash_irq` = 1 and persists across frames. Asserting `irq_clr` for 1 cycle clears it; `irq_clr` asserted in the same cycle as a new crash leaves it set.

Source files
------------

// File: rtl/race_game_fsm_if.sv
// ---------------------------------------------------------------------------
// race_game_fsm_if
// Bundles the pixel-stream inputs, the register-bank start/status signals and
// (optionally) the crash interrupt of race_game_fsm.
//
// Signals
//   pix_row, pix_col    : current pixel coordinates from the display pipeline
//   video_on            : visible-region qualifier
//   player_car_in       : player layer RGB (12'h000 = transparent)
//   moving_cars_in      : traffic layer RGB (12'h000 = transparent)
//   start               : level signal from the register bank (rising edge used)
//   game_state          : 0 = IDLE, 1 = RUN, 2 = CRASH
//   crash               : high while in CRASH
//   score               : RUN frames completed, saturating
//   level               : 0..3, saturating
//   frame_tick          : one-cycle pulse at each frame end
//   crash_irq, irq_clr  : sticky crash interrupt and its clear
//                         (only when CRASH_IRQ_EN is defined)
//
// Modports
//   master : the driving side (display pipeline / register bank / bench)
//   slave  : the game-control block
//
// Optional feature macro: CRASH_IRQ_EN
// ---------------------------------------------------------------------------
interface race_game_fsm_if;
  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        video_on;
  logic [11:0] player_car_in;
  logic [11:0] moving_cars_in;
  logic        start;
  logic [1:0]  game_state;
  logic        crash;
  logic [15:0] score;
  logic [1:0]  level;
  logic        frame_tick;
`ifdef CRASH_IRQ_EN
  logic        crash_irq;
  logic        irq_clr;
`endif

  modport master (
    output pix_row, pix_col, video_on, player_car_in, moving_cars_in, start,
`ifdef CRASH_IRQ_EN
    output irq_clr,
    input  crash_irq,
`endif
    input  game_state, crash, score, level, frame_tick
  );

  modport slave (
    input  pix_row, pix_col, video_on, player_car_in, moving_cars_in, start,
`ifdef CRASH_IRQ_EN
    input  irq_clr,
    output crash_irq,
`endif
    output game_state, crash, score, level, frame_tick
  );
endinterface

// File: rtl/race_game_fsm.sv
// ---------------------------------------------------------------------------
// race_game_fsm
// Game-control stage on the VGA pixel clock. Registers the per-pixel layer
// outputs, counts player/traffic overlap per frame, runs the IDLE/RUN/CRASH
// state machine, keeps a saturating per-frame score and a 2-bit speed level.
//
// Ports
//   clk    : VGA pixel clock (only clock)
//   rst_n  : asynchronous active-low reset
//   bus    : race_game_fsm_if.slave (pixel inputs, start, status outputs)
//
// Parameters
//   ACTIVE_ROWS  : first non-visible row; frame end is its rising crossing
//   OVERLAP_MIN  : overlapping pixels per frame that count as a crash
//   LEVEL_FRAMES : clean RUN frames per level step
//   CRASH_FRAMES : frame ticks spent in CRASH before returning to IDLE
//
// Optional feature macro: CRASH_IRQ_EN (adds sticky crash_irq / irq_clr)
// ---------------------------------------------------------------------------
module race_game_fsm #(
  parameter int ACTIVE_ROWS  = 480,
  parameter int OVERLAP_MIN  = 4,
  parameter int LEVEL_FRAMES = 1800,
  parameter int CRASH_FRAMES = 120
) (
  input  logic            clk,
  input  logic            rst_n,
  race_game_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  localparam logic [9:0]  ROW_LIMIT   = 10'(ACTIVE_ROWS);
  localparam logic [15:0] OVL_MIN_C   = 16'(OVERLAP_MIN);
  localparam logic [15:0] LEVEL_C     = 16'(LEVEL_FRAMES);
  localparam logic [15:0] CRASH_C     = 16'(CRASH_FRAMES);

  // Input stage (the column is not needed by any decision, so it is not kept)
  logic [9:0]  row_q;
  logic        video_on_q;
  logic [11:0] player_q;
  logic [11:0] traffic_q;
  logic        start_q;
  logic        start_prev_q;

  // Frame-end detection
  logic        row_ge_q;
  logic        frame_tick_q;

  // Game state
  state_t      state_q, state_d;
  logic        crash_q, crash_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  level_q, level_d;
  logic [15:0] ovl_cnt_q, ovl_cnt_d;
  logic [15:0] lvl_cnt_q, lvl_cnt_d;
  logic [15:0] crash_cnt_q, crash_cnt_d;

  logic        row_ge;
  logic        ovl_pix;
  logic        start_rise;

  assign row_ge     = (row_q >= ROW_LIMIT);
  assign ovl_pix    = video_on_q && (player_q != 12'h000) && (traffic_q != 12'h000);
  assign start_rise = start_q && !start_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      video_on_q   <= 1'b0;
      player_q     <= '0;
      traffic_q    <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      row_ge_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      state_q      <= ST_IDLE;
      crash_q      <= 1'b0;
      score_q      <= '0;
      level_q      <= '0;
      ovl_cnt_q    <= '0;
      lvl_cnt_q    <= '0;
      crash_cnt_q  <= '0;
    end else begin
      row_q        <= bus.pix_row;
      video_on_q   <= bus.video_on;
      player_q     <= bus.player_car_in;
      traffic_q    <= bus.moving_cars_in;
      start_q      <= bus.start;
      start_prev_q <= start_q;
      row_ge_q     <= row_ge;
      // One pulse per frame: only the rising crossing of the active limit
      frame_tick_q <= row_ge && !row_ge_q;
      state_q      <= state_d;
      crash_q      <= crash_d;
      score_q      <= score_d;
      level_q      <= level_d;
      ovl_cnt_q    <= ovl_cnt_d;
      lvl_cnt_q    <= lvl_cnt_d;
      crash_cnt_q  <= crash_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    level_d     = level_q;
    lvl_cnt_d   = lvl_cnt_q;
    crash_cnt_d = crash_cnt_q;

    // The count for a frame is consumed at frame_tick, then restarts
    if (frame_tick_q) begin
      ovl_cnt_d = '0;
    end else if (ovl_pix && (ovl_cnt_q != 16'hFFFF)) begin
      ovl_cnt_d = ovl_cnt_q + 16'd1;
    end else begin
      ovl_cnt_d = ovl_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Start edge beats a coincident frame_tick: that tick is not scored
        if (start_rise) begin
          state_d     = ST_RUN;
          score_d     = '0;
          level_d     = '0;
          lvl_cnt_d   = '0;
          crash_cnt_d = '0;
          ovl_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (frame_tick_q) begin
          if (ovl_cnt_q >= OVL_MIN_C) begin
            state_d     = ST_CRASH;
            crash_cnt_d = '0;
          end else begin
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end
            if ((lvl_cnt_q + 16'd1) == LEVEL_C) begin
              lvl_cnt_d = '0;
              if (level_q != 2'd3) begin
                level_d = level_q + 2'd1;
              end
            end else begin
              lvl_cnt_d = lvl_cnt_q + 16'd1;
            end
          end
        end
      end
      ST_CRASH: begin
        if (frame_tick_q) begin
          if ((crash_cnt_q + 16'd1) == CRASH_C) begin
            state_d     = ST_IDLE;
            crash_cnt_d = '0;
          end else begin
            crash_cnt_d = crash_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from the next state so crash tracks game_state exactly
    crash_d = (state_d == ST_CRASH);
  end

`ifdef CRASH_IRQ_EN
  logic irq_clr_q;
  logic crash_irq_q, crash_irq_d;
  logic irq_set;

  assign irq_set = (state_q == ST_RUN) && (state_d == ST_CRASH);

  // Set has priority over a clear in the same cycle
  always_comb begin
    crash_irq_d = crash_irq_q;
    if (irq_set) begin
      crash_irq_d = 1'b1;
    end else if (irq_clr_q) begin
      crash_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_clr_q   <= 1'b0;
      crash_irq_q <= 1'b0;
    end else begin
      irq_clr_q   <= bus.irq_clr;
      crash_irq_q <= crash_irq_d;
    end
  end

  assign bus.crash_irq = crash_irq_q;
`endif

  assign bus.game_state = state_q;
  assign bus.crash      = crash_q;
  assign bus.score      = score_q;
  assign bus.level      = level_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_race_game_fsm.sv
// ---------------------------------------------------------------------------
// tb_race_game_fsm
// Directed bench for race_game_fsm using a shrunken frame (9 rows x 8 cols,
// rows 0..5 active). Inputs are driven and outputs sampled on the falling
// clock edge. Optional CRASH_IRQ_EN checks are compiled in when defined.
// ---------------------------------------------------------------------------
module tb_race_game_fsm;

  localparam int ACT   = 6;
  localparam int ROWS  = 9;
  localparam int COLS  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  race_game_fsm_if bus ();

  race_game_fsm #(
    .ACTIVE_ROWS  (ACT),
    .OVERLAP_MIN  (4),
    .LEVEL_FRAMES (2),
    .CRASH_FRAMES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  always @(negedge clk) begin
    if (bus.frame_tick === 1'b1) ticks++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame; the first n_ovl visible pixels overlap, other visible
  // pixels carry disjoint car/traffic, and one blanked pixel per active row
  // carries both layers to exercise the video_on qualifier.
  task automatic run_frame(input int n_ovl, input bit clr_at_tick);
    int k;
    k = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        bus.pix_row        = 10'(r);
        bus.pix_col        = 10'(c);
        bus.video_on       = (r < ACT) && (c < 6);
        bus.player_car_in  = 12'h000;
        bus.moving_cars_in = 12'h000;
        if (bus.video_on) begin
          if (k < n_ovl) begin
            bus.player_car_in  = 12'hF00;
            bus.moving_cars_in = 12'h0F0;
          end else if (c == 1) begin
            bus.player_car_in  = 12'h00F;
          end else if (c == 2) begin
            bus.moving_cars_in = 12'h0F0;
          end
          k++;
        end else if (r < ACT && c == 7) begin
          bus.player_car_in  = 12'hFFF;
          bus.moving_cars_in = 12'hFFF;
        end
`ifdef CRASH_IRQ_EN
        // Lands irq_clr_q in the cycle where frame_tick is high
        bus.irq_clr = clr_at_tick && (r == ACT) && (c == 1);
`else
        if (clr_at_tick && r < 0) k = k;
`endif
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [1:0] exp_lvl [10];

  initial begin
    bus.pix_row = '0; bus.pix_col = '0; bus.video_on = 1'b0;
    bus.player_car_in = '0; bus.moving_cars_in = '0; bus.start = 1'b0;
`ifdef CRASH_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    exp_lvl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    // Reset state
    #1;
    chk("rst_state", 32'(bus.game_state), 32'd0);
    chk("rst_crash", 32'(bus.crash), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_tick",  32'(bus.frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // No start: stays IDLE across a frame
    run_frame(0, 1'b0);
    chk("idle_nostart_state", 32'(bus.game_state), 32'd0);
    chk("idle_nostart_ticks", 32'(ticks), 32'd1);

    // Start edge to RUN takes two cycles
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); chk("start_lat1", 32'(bus.game_state), 32'd0);
    @(negedge clk); chk("start_lat2", 32'(bus.game_state), 32'd1);
    bus.start = 1'b0;
    ticks = 0;

    // Ten clean frames, level steps every two frames and saturates
    for (int f = 0; f < 10; f++) begin
      run_frame(0, 1'b0);
      chk($sformatf("clean_level_f%0d", f + 1), 32'(bus.level), 32'(exp_lvl[f]));
    end
    chk("clean_score", 32'(bus.score), 32'd10);
    chk("clean_crash", 32'(bus.crash), 32'd0);
    chk("clean_ticks", 32'(ticks), 32'd10);
    chk("clean_state", 32'(bus.game_state), 32'd1);

    // Below threshold: still running and scored
    run_frame(3, 1'b0);
    chk("ovl3_state", 32'(bus.game_state), 32'd1);
    chk("ovl3_score", 32'(bus.score), 32'd11);

    // At threshold: crash, score frozen (irq_clr coincident with set)
    run_frame(4, 1'b1);
    chk("ovl4_state", 32'(bus.game_state), 32'd2);
    chk("ovl4_crash", 32'(bus.crash), 32'd1);
    chk("ovl4_score", 32'(bus.score), 32'd11);
    chk("ovl4_level", 32'(bus.level), 32'd3);
`ifdef CRASH_IRQ_EN
    chk("irq_set_wins", 32'(bus.crash_irq), 32'd1);
`endif

    // Start during CRASH is ignored
    pulse_start();
    run_frame(0, 1'b0);
    chk("crash_f1_state", 32'(bus.game_state), 32'd2);
`ifdef CRASH_IRQ_EN
    chk("irq_persist", 32'(bus.crash_irq), 32'd1);
    @(negedge clk); bus.irq_clr = 1'b1;
    @(negedge clk); bus.irq_clr = 1'b0;
    @(negedge clk); chk("irq_cleared", 32'(bus.crash_irq), 32'd0);
`endif
    bus.start = 1'b1;   // held high through the return to IDLE
    run_frame(0, 1'b0);
    chk("crash_f2_state", 32'(bus.game_state), 32'd2);
    run_frame(0, 1'b0);
    chk("crash_f3_state", 32'(bus.game_state), 32'd0);
    chk("crash_f3_crash", 32'(bus.crash), 32'd0);
    chk("idle_score_hold", 32'(bus.score), 32'd11);
    chk("idle_level_hold", 32'(bus.level), 32'd3);
    run_frame(0, 1'b0);
    chk("held_start_no_restart", 32'(bus.game_state), 32'd0);

    // Fresh edge restarts with cleared score/level
    bus.start = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("restart_state", 32'(bus.game_state), 32'd1);
    chk("restart_score", 32'(bus.score), 32'd0);
    chk("restart_level", 32'(bus.level), 32'd0);
    for (int f = 0; f < 5; f++) run_frame(0, 1'b0);
    chk("run5_score", 32'(bus.score), 32'd5);
    chk("run5_level", 32'(bus.level), 32'd2);

    // Asynchronous reset mid-frame while running
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.pix_row  = 10'(c / COLS);
      bus.pix_col  = 10'(c % COLS);
      bus.video_on = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.game_state), 32'd0);
    chk("arst_score", 32'(bus.score), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_crash", 32'(bus.crash), 32'd0);
    chk("arst_tick",  32'(bus.frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1'b0);
    chk("post_rst_state", 32'(bus.game_state), 32'd0);
    chk("post_rst_score", 32'(bus.score), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
